mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter WAIT_CYCLES, default 2: memory access cycles per read/write, legal range 1..15.
REQ-002 Clk  input  1  system clock; all state changes on the rising edge.
REQ-003 Reset  input  1  asynchronous, active-high reset.
REQ-004 BUS  input  16  value driven onto the shared datapath bus.
REQ-005 LD_MAR  input  1  load the MAR from BUS.
REQ-006 LD_MDR  input  1  load the MDR from BUS. Ignored while MIO_EN=1.
REQ-007 MIO_EN  input  1  memory-I/O enable; the MDR source becomes the memory read data.
REQ-008 MEM_RD  input  1  start a read at address MAR.
REQ-009 MEM_WR  input  1  start a write of MDR to address MAR.
REQ-010 MEM_RDATA  input  16  data returned by memory.
REQ-011 SW  input  16  switch value, used for memory-mapped I/O reads.
REQ-012 MAR  output  16  address register.
REQ-013 MDR  output  16  data register; this feeds the bus mux.
REQ-014 MEM_ADDR  output  16  memory address; always equals MAR.
REQ-015 MEM_WDATA  output  16  memory write data; always equals MDR.
REQ-016 MEM_OE  output  1  read strobe, active-high.
REQ-017 MEM_WE  output  1  write strobe, active-high.
REQ-018 BUSY  output  1  high whenever the state is not IDLE.
REQ-019 R  output  1  one-cycle ready pulse that marks completion.
REQ-020 HEX_OUT  output  16  memory-mapped display register.

Function
REQ-021 The unit SHALL have four states: IDLE, RD_WAIT, WR_WAIT, DONE. Transitions:
- DONE always returns to IDLE.
- BUSY = (state != IDLE).
REQ-022 Register loads in IDLE:
- LD_MAR loads MAR from BUS.
- LD_MDR with MIO_EN=0 loads MDR from BUS.
- In every other state, LD_MAR and LD_MDR are ignored.
REQ-023 Read request in IDLE: MEM_RD=1 at edge N moves the state to RD_WAIT for WAIT_CYCLES cycles, with MEM_OE=1 throughout.
- If MIO_EN=1, MDR <= MEM_RDATA at the edge that ends the last wait cycle.
- The state then goes to DONE, and R=1 in cycle N+WAIT_CYCLES+1.
REQ-024 Write request: MEM_WR=1 in IDLE moves the state to WR_WAIT for WAIT_CYCLES cycles, with MEM_WE=1 throughout, then DONE with the same timing as a read. MDR is unchanged.
REQ-025 MEM_RD and MEM_WR asserted together in IDLE: the read wins and the write is dropped.
REQ-026 MEM_RD or MEM_WR asserted outside IDLE SHALL be ignored; requests are not queued.
REQ-027 MEM_OE and MEM_WE SHALL never be high in the same cycle; both are 0 in IDLE and DONE.
REQ-028 The wait counter is 4 bits, loaded with WAIT_CYCLES-1 on entry and decremented down to 0. It does not wrap.

Reset
REQ-029 Reset SHALL asynchronously force the following, regardless of the current state:
- state = IDLE
- MAR = 0, MDR = 0, HEX_OUT = 0
- MEM_OE = 0, MEM_WE = 0, R = 0, BUSY = 0
REQ-030 Reset during RD_WAIT or WR_WAIT SHALL abort the access with no MDR update and no R pulse.

Configuration
REQ-031 Macro MEM_IO_MAP_EN, when defined, enables memory-mapped I/O at address 16'hFFFF:
- A read goes from IDLE directly to DONE and sets MDR <= SW (if MIO_EN=1); R=1 in cycle N+1.
- A write goes from IDLE directly to DONE and sets HEX_OUT <= MDR.
- Neither case asserts MEM_OE or MEM_WE.
REQ-032 Without MEM_IO_MAP_EN:
- Address 16'hFFFF is treated as ordinary memory.
- SW is ignored.
- HEX_OUT is held at 0.

Structure
REQ-033 Package lc3_mem_pkg SHALL hold the state enum and the constant MMIO_ADDR = 16'hFFFF.
REQ-034 MAR, MDR and HEX_OUT SHALL be instances of one sub-module, reg_16: a 16-bit register with load enable and async reset.

Verification
REQ-035 The bench SHALL cover these scenarios, with WAIT_CYCLES=2 unless stated:
- Write then read: BUS=16'h1234 with LD_MAR; BUS=16'hBEEF with LD_MDR; pulse MEM_WR. Expect MEM_WE high for 2 cycles at MEM_ADDR=16'h1234, then an R pulse. Next, MIO_EN=1, MEM_RDATA=16'hCAFE, pulse MEM_RD. Expect MDR=16'hCAFE in the same cycle as the R pulse, 3 cycles after the request.
- Busy protection: during RD_WAIT, assert LD_MAR with BUS=16'h0042 and pulse MEM_WR. Expect MAR unchanged and exactly one R pulse.
- Simultaneous requests: MEM_RD and MEM_WR together in IDLE. Expect MEM_OE only, and MEM_WE never high.
- Mid-access reset: assert Reset in the first RD_WAIT cycle. Expect all outputs 0 immediately and no R pulse.
- MMIO, with MEM_IO_MAP_EN defined: MAR=16'hFFFF, MDR=16'h00A5, pulse MEM_WR. Expect HEX_OUT=16'h00A5 and R in cycle N+1. Then SW=16'h0F0F with a read. Expect MDR=16'h0F0F.
- WAIT_CYCLES=1 and WAIT_CYCLES=15: R arrives exactly 2 and 16 cycles after the request, respectively.

Source files
------------

// File: rtl/lc3_mem_pkg.sv
// Shared definitions for the LC-3 style memory access unit: state names and the
// memory-mapped I/O address.
package lc3_mem_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RD_WAIT = 2'd1,
      WR_WAIT = 2'd2,
      DONE    = 2'd3
   } mem_state_e;

   // Plain-vector copies of the state names for logic that stores state as logic [1:0]
   localparam logic [1:0] ST_IDLE    = IDLE;
   localparam logic [1:0] ST_RD_WAIT = RD_WAIT;
   localparam logic [1:0] ST_WR_WAIT = WR_WAIT;
   localparam logic [1:0] ST_DONE    = DONE;

   localparam logic [15:0] MMIO_ADDR = 16'hFFFF;

   function automatic logic [3:0] wait_load(input int cycles);
      return 4'(cycles - 1);
   endfunction

endpackage

// File: rtl/reg_16.sv
// 16-bit register with load enable and asynchronous active-high reset.
module reg_16 (
   input  logic        clk,
   input  logic        rst,
   input  logic        ld,
   input  logic [15:0] d,
   output logic [15:0] q
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         q <= '0;
      else if (ld)
         q <= d;
   end

endmodule

// File: rtl/mem_access_unit.sv
// Memory access unit: MAR/MDR, a wait-state read/write sequencer and an optional
// memory-mapped display/switch port at 16'hFFFF, enabled by defining MEM_IO_MAP_EN.
module mem_access_unit
   import lc3_mem_pkg::*;
#(
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] bus,
   input  logic        ld_mar,
   input  logic        ld_mdr,
   input  logic        mio_en,
   input  logic        mem_rd,
   input  logic        mem_wr,
   input  logic [15:0] mem_rdata,
   input  logic [15:0] sw,
   output logic [15:0] mar,
   output logic [15:0] mdr,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_wdata,
   output logic        mem_oe,
   output logic        mem_we,
   output logic        busy,
   output logic        r,
   output logic [15:0] hex_out
);

   logic [1:0]  state;
   logic [1:0]  state_next;
   logic [3:0]  wait_cnt;
   logic [3:0]  wait_cnt_next;
   logic        idle;
   logic        last_wait;
   logic        mmio_hit;
   logic        mar_ld;
   logic        mdr_ld;
   logic [15:0] mdr_d;
   logic        mdr_from_bus;
   logic        mdr_from_mem;
   logic        mdr_from_sw;
   logic        hex_ld;

   assign idle      = (state == ST_IDLE);
   assign last_wait = (wait_cnt == 4'd0);

`ifdef MEM_IO_MAP_EN
   assign mmio_hit = (mar == MMIO_ADDR);
`else
   assign mmio_hit = 1'b0;
`endif

   // Requests are only accepted in IDLE; a read takes priority over a write
   always_comb begin
      state_next    = state;
      wait_cnt_next = wait_cnt;
      case (state)
         ST_IDLE: begin
            if (mem_rd) begin
               state_next    = mmio_hit ? ST_DONE : ST_RD_WAIT;
               wait_cnt_next = wait_load(WAIT_CYCLES);
            end else if (mem_wr) begin
               state_next    = mmio_hit ? ST_DONE : ST_WR_WAIT;
               wait_cnt_next = wait_load(WAIT_CYCLES);
            end
         end
         ST_RD_WAIT, ST_WR_WAIT: begin
            if (last_wait)
               state_next = ST_DONE;
            else
               wait_cnt_next = wait_cnt - 4'd1;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_IDLE;
         wait_cnt <= 4'd0;
      end else begin
         state    <= state_next;
         wait_cnt <= wait_cnt_next;
      end
   end

   assign mar_ld       = idle && ld_mar;
   assign mdr_from_bus = idle && ld_mdr && !mio_en;
   assign mdr_from_mem = (state == ST_RD_WAIT) && last_wait && mio_en;
   assign mdr_from_sw  = idle && mem_rd && mmio_hit && mio_en;
   assign mdr_ld       = mdr_from_bus || mdr_from_mem || mdr_from_sw;
   assign mdr_d        = mdr_from_mem ? mem_rdata :
                         mdr_from_sw  ? sw        : bus;

   // Display register only captures on a memory-mapped write that is not shadowed by a read
   assign hex_ld = idle && mem_wr && !mem_rd && mmio_hit;

   reg_16 u_mar (
      .clk (clk),
      .rst (rst),
      .ld  (mar_ld),
      .d   (bus),
      .q   (mar)
   );

   reg_16 u_mdr (
      .clk (clk),
      .rst (rst),
      .ld  (mdr_ld),
      .d   (mdr_d),
      .q   (mdr)
   );

   reg_16 u_hex (
      .clk (clk),
      .rst (rst),
      .ld  (hex_ld),
      .d   (mdr),
      .q   (hex_out)
   );

   assign mem_addr  = mar;
   assign mem_wdata = mdr;
   assign mem_oe    = (state == ST_RD_WAIT);
   assign mem_we    = (state == ST_WR_WAIT);
   assign busy      = !idle;
   assign r         = (state == ST_DONE);

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: three instances (WAIT_CYCLES 2, 1, 15) share one stimulus
// stream and are checked every cycle against a transaction-level model.
module tb_mem_access_unit;

   localparam int NDUT = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] bus = '0;
   logic        ld_mar = 1'b0;
   logic        ld_mdr = 1'b0;
   logic        mio_en = 1'b0;
   logic        mem_rd = 1'b0;
   logic        mem_wr = 1'b0;
   logic [15:0] mem_rdata = '0;
   logic [15:0] sw = '0;

   logic [15:0] d_mar   [NDUT];
   logic [15:0] d_mdr   [NDUT];
   logic [15:0] d_addr  [NDUT];
   logic [15:0] d_wdata [NDUT];
   logic [15:0] d_hex   [NDUT];
   logic        d_oe    [NDUT];
   logic        d_we    [NDUT];
   logic        d_busy  [NDUT];
   logic        d_r     [NDUT];

   int vec_count  = 0;
   int miss_count = 0;

   always #5 clk = ~clk;

   mem_access_unit #(.WAIT_CYCLES(2)) u_w2 (
      .clk(clk), .rst(rst), .bus(bus), .ld_mar(ld_mar), .ld_mdr(ld_mdr), .mio_en(mio_en),
      .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_rdata(mem_rdata), .sw(sw),
      .mar(d_mar[0]), .mdr(d_mdr[0]), .mem_addr(d_addr[0]), .mem_wdata(d_wdata[0]),
      .mem_oe(d_oe[0]), .mem_we(d_we[0]), .busy(d_busy[0]), .r(d_r[0]), .hex_out(d_hex[0])
   );

   mem_access_unit #(.WAIT_CYCLES(1)) u_w1 (
      .clk(clk), .rst(rst), .bus(bus), .ld_mar(ld_mar), .ld_mdr(ld_mdr), .mio_en(mio_en),
      .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_rdata(mem_rdata), .sw(sw),
      .mar(d_mar[1]), .mdr(d_mdr[1]), .mem_addr(d_addr[1]), .mem_wdata(d_wdata[1]),
      .mem_oe(d_oe[1]), .mem_we(d_we[1]), .busy(d_busy[1]), .r(d_r[1]), .hex_out(d_hex[1])
   );

   mem_access_unit #(.WAIT_CYCLES(15)) u_w15 (
      .clk(clk), .rst(rst), .bus(bus), .ld_mar(ld_mar), .ld_mdr(ld_mdr), .mio_en(mio_en),
      .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_rdata(mem_rdata), .sw(sw),
      .mar(d_mar[2]), .mdr(d_mdr[2]), .mem_addr(d_addr[2]), .mem_wdata(d_wdata[2]),
      .mem_oe(d_oe[2]), .mem_we(d_we[2]), .busy(d_busy[2]), .r(d_r[2]), .hex_out(d_hex[2])
   );

   function automatic int wait_of(input int idx);
      case (idx)
         0:       return 2;
         1:       return 1;
         default: return 15;
      endcase
   endfunction

   task automatic check_output(input string name, input int idx, input logic [15:0] act,
                               input logic [15:0] exp);
      vec_count++;
      if (act !== exp) begin
         miss_count++;
         $display("[TB] FAIL %s dut%0d (W=%0d) at %0t: got %h expected %h",
                  name, idx, wait_of(idx), $time, act, exp);
      end
   endtask

   // Model: an access lasts W wait cycles plus one completion cycle (one cycle for MMIO)
   localparam int K_NONE = 0;
   localparam int K_RD   = 1;
   localparam int K_WR   = 2;

   int          m_left [NDUT] = '{0, 0, 0};
   int          m_kind [NDUT] = '{0, 0, 0};
   logic [15:0] m_mar  [NDUT] = '{16'h0, 16'h0, 16'h0};
   logic [15:0] m_mdr  [NDUT] = '{16'h0, 16'h0, 16'h0};
   logic [15:0] m_hex  [NDUT] = '{16'h0, 16'h0, 16'h0};

   always @(posedge clk or posedge rst) begin
      for (int i = 0; i < NDUT; i++) begin
         if (rst) begin
            m_left[i] = 0;
            m_kind[i] = K_NONE;
            m_mar[i]  = 16'h0;
            m_mdr[i]  = 16'h0;
            m_hex[i]  = 16'h0;
         end else if (m_left[i] > 0) begin
            if (m_left[i] == 2 && m_kind[i] == K_RD && mio_en)
               m_mdr[i] = mem_rdata;
            m_left[i]--;
         end else begin
            logic [15:0] old_mar;
            logic [15:0] old_mdr;
            logic        is_mmio;
            old_mar = m_mar[i];
            old_mdr = m_mdr[i];
`ifdef MEM_IO_MAP_EN
            is_mmio = (old_mar == 16'hFFFF);
`else
            is_mmio = 1'b0;
`endif
            if (ld_mar)
               m_mar[i] = bus;
            if (ld_mdr && !mio_en)
               m_mdr[i] = bus;
            if (mem_rd) begin
               m_kind[i] = K_RD;
               m_left[i] = is_mmio ? 1 : wait_of(i) + 1;
               if (is_mmio && mio_en)
                  m_mdr[i] = sw;
            end else if (mem_wr) begin
               m_kind[i] = K_WR;
               m_left[i] = is_mmio ? 1 : wait_of(i) + 1;
               if (is_mmio)
                  m_hex[i] = old_mdr;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         for (int i = 0; i < NDUT; i++) begin
            check_output("mar",       i, d_mar[i],   m_mar[i]);
            check_output("mdr",       i, d_mdr[i],   m_mdr[i]);
            check_output("mem_addr",  i, d_addr[i],  m_mar[i]);
            check_output("mem_wdata", i, d_wdata[i], m_mdr[i]);
            check_output("hex_out",   i, d_hex[i],   m_hex[i]);
            check_output("busy",      i, 16'(d_busy[i]), 16'(m_left[i] > 0));
            check_output("r",         i, 16'(d_r[i]),    16'(m_left[i] == 1));
            check_output("mem_oe",    i, 16'(d_oe[i]),   16'(m_kind[i] == K_RD && m_left[i] > 1));
            check_output("mem_we",    i, 16'(d_we[i]),   16'(m_kind[i] == K_WR && m_left[i] > 1));
         end
      end
   end

   int   r_first [NDUT];
   int   r_count [NDUT];
   logic oe_seen [NDUT];
   logic we_seen [NDUT];

   task automatic apply_stimulus(input logic lm, input logic lmd, input logic mio,
                                 input logic rd, input logic wr, input logic [15:0] b);
      @(negedge clk);
      ld_mar = lm;
      ld_mdr = lmd;
      mio_en = mio;
      mem_rd = rd;
      mem_wr = wr;
      bus    = b;
   endtask

   task automatic clear_flags();
      for (int i = 0; i < NDUT; i++) begin
         r_first[i] = -1;
         r_count[i] = 0;
         oe_seen[i] = 1'b0;
         we_seen[i] = 1'b0;
      end
   endtask

   task automatic sample_flags(input int k);
      for (int i = 0; i < NDUT; i++) begin
         if (d_r[i]) begin
            r_count[i]++;
            if (r_first[i] < 0)
               r_first[i] = k;
         end
         if (d_oe[i]) oe_seen[i] = 1'b1;
         if (d_we[i]) we_seen[i] = 1'b1;
      end
   endtask

   task automatic run_window(input logic mio, input int from_k, input int to_k);
      for (int k = from_k; k <= to_k; k++) begin
         apply_stimulus(1'b0, 1'b0, mio, 1'b0, 1'b0, 16'h0);
         sample_flags(k);
      end
   endtask

   task automatic wait_all_idle(input logic mio);
      int n;
      n = 0;
      apply_stimulus(1'b0, 1'b0, mio, 1'b0, 1'b0, 16'h0);
      while ((d_busy[0] || d_busy[1] || d_busy[2]) && n < 40) begin
         apply_stimulus(1'b0, 1'b0, mio, 1'b0, 1'b0, 16'h0);
         n++;
      end
      check_output("idle_timeout", 0, 16'(d_busy[0] || d_busy[1] || d_busy[2]), 16'h0);
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      clear_flags();
      repeat (2) @(negedge clk);
      check_output("rst_mar",  0, d_mar[0], 16'h0);
      check_output("rst_mdr",  0, d_mdr[0], 16'h0);
      check_output("rst_hex",  0, d_hex[0], 16'h0);
      check_output("rst_busy", 0, 16'(d_busy[0]), 16'h0);
      check_output("rst_r",    0, 16'(d_r[0]), 16'h0);
      rst = 1'b0;

      // Write 16'hBEEF to 16'h1234
      apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h1234);
      apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'hBEEF);
      apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0);
      apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
      check_output("wr_we_c1",    0, 16'(d_we[0]), 16'h1);
      check_output("wr_addr_c1",  0, d_addr[0], 16'h1234);
      check_output("wr_wdata_c1", 0, d_wdata[0], 16'hBEEF);
      apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
      check_output("wr_we_c2", 0, 16'(d_we[0]), 16'h1);
      check_output("wr_r_c2",  0, 16'(d_r[0]), 16'h0);
      apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
      check_output("wr_r_c3",  0, 16'(d_r[0]), 16'h1);
      check_output("wr_we_c3", 0, 16'(d_we[0]), 16'h0);
      wait_all_idle(1'b0);

      // Read back with MIO_EN; R latency is W+1 for every instance
      mem_rdata = 16'hCAFE;
      apply_stimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0);
      clear_flags();
      for (int k = 1; k <= 20; k++) begin
         apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
         sample_flags(k);
         if (k == 3) begin
            check_output("rd_r_c3",   0, 16'(d_r[0]), 16'h1);
            check_output("rd_mdr_c3", 0, d_mdr[0], 16'hCAFE);
         end
      end
      check_output("rd_latency", 0, 16'(r_first[0]), 16'd3);
      check_output("rd_latency", 1, 16'(r_first[1]), 16'd2);
      check_output("rd_latency", 2, 16'(r_first[2]), 16'd16);
      check_output("rd_mdr_end", 2, d_mdr[2], 16'hCAFE);

      // Loads and a write request arriving during RD_WAIT are ignored
      mem_rdata = 16'h1111;
      apply_stimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0);
      clear_flags();
      apply_stimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0042);
      sample_flags(1);
      run_window(1'b1, 2, 20);
      for (int i = 0; i < NDUT; i++) begin
         check_output("busy_r_count", i, 16'(r_count[i]), 16'd1);
         check_output("busy_no_we",   i, 16'(we_seen[i]), 16'h0);
         check_output("busy_mar",     i, d_mar[i], 16'h1234);
      end

      // Simultaneous read and write: read wins
      apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0);
      clear_flags();
      run_window(1'b0, 1, 20);
      for (int i = 0; i < NDUT; i++) begin
         check_output("both_oe_seen", i, 16'(oe_seen[i]), 16'h1);
         check_output("both_we_seen", i, 16'(we_seen[i]), 16'h0);
         check_output("both_r_count", i, 16'(r_count[i]), 16'd1);
      end

      // Asynchronous reset in the first RD_WAIT cycle
      mem_rdata = 16'hDEAD;
      apply_stimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0);
      apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
      check_output("pre_rst_oe", 0, 16'(d_oe[0]), 16'h1);
      #1 rst = 1'b1;
      #1;
      for (int i = 0; i < NDUT; i++) begin
         check_output("arst_busy", i, 16'(d_busy[i]), 16'h0);
         check_output("arst_oe",   i, 16'(d_oe[i]), 16'h0);
         check_output("arst_r",    i, 16'(d_r[i]), 16'h0);
         check_output("arst_mar",  i, d_mar[i], 16'h0);
         check_output("arst_mdr",  i, d_mdr[i], 16'h0);
      end
      @(negedge clk);
      rst = 1'b0;
      clear_flags();
      run_window(1'b1, 1, 20);
      for (int i = 0; i < NDUT; i++) begin
         check_output("arst_no_r", i, 16'(r_count[i]), 16'd0);
         check_output("arst_mdr_after", i, d_mdr[i], 16'h0);
      end

      // Access to 16'hFFFF: display/switch port when enabled, plain memory otherwise
      mem_rdata = 16'h5A5A;
      sw        = 16'h0F0F;
      apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'hFFFF);
      apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h00A5);
      apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0);
      apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
      for (int i = 0; i < NDUT; i++) begin
`ifdef MEM_IO_MAP_EN
         check_output("mmio_wr_r",   i, 16'(d_r[i]), 16'h1);
         check_output("mmio_wr_we",  i, 16'(d_we[i]), 16'h0);
         check_output("mmio_wr_hex", i, d_hex[i], 16'h00A5);
`else
         check_output("plain_wr_we",  i, 16'(d_we[i]), 16'h1);
         check_output("plain_wr_hex", i, d_hex[i], 16'h0);
`endif
      end
      wait_all_idle(1'b1);
      apply_stimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0);
      apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
      for (int i = 0; i < NDUT; i++) begin
`ifdef MEM_IO_MAP_EN
         check_output("mmio_rd_r",   i, 16'(d_r[i]), 16'h1);
         check_output("mmio_rd_oe",  i, 16'(d_oe[i]), 16'h0);
         check_output("mmio_rd_mdr", i, d_mdr[i], 16'h0F0F);
`else
         check_output("plain_rd_oe", i, 16'(d_oe[i]), 16'h1);
`endif
      end
      wait_all_idle(1'b1);
`ifndef MEM_IO_MAP_EN
      for (int i = 0; i < NDUT; i++) begin
         check_output("plain_rd_mdr", i, d_mdr[i], 16'h5A5A);
         check_output("plain_hex",    i, d_hex[i], 16'h0);
      end
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
      $finish;
   end

endmodule
